// File: rtl/axi_rd_req_gen.sv
// Read request generator: splits a bulk read command into rx_req chunks that are
// bounded by MAX_CHUNK words and never cross a 4 KB address boundary.
module axi_rd_req_gen #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
   parameter int unsigned TX_SIZE_WIDTH      = 6,
   parameter int unsigned TOTAL_WIDTH        = 20,
   parameter int unsigned MAX_CHUNK          = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [TOTAL_WIDTH-1:0]        cmd_words,
   output logic                          rx_req,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] rx_addr,
   output logic [TX_SIZE_WIDTH-1:0]      rx_req_size,
   input  logic                          rx_done,
   output logic                          busy,
   output logic                          cmd_done,
   output logic [15:0]                   chunk_cnt
);

   localparam int unsigned Bpw     = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned AddrLsb = $clog2(Bpw);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrLowMask = C_M_AXI_ADDR_WIDTH'(Bpw - 1);
   localparam logic [TOTAL_WIDTH-1:0]        MaxChunkW   = TOTAL_WIDTH'(MAX_CHUNK);

   typedef enum logic [2:0] {StIdle, StCalc, StReq, StWait, StDone} state_e;

   state_e                          state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
   logic [TOTAL_WIDTH-1:0]          rem_q, rem_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   rx_addr_q, rx_addr_d;
   logic [TX_SIZE_WIDTH-1:0]        rx_size_q, rx_size_d;
   logic [15:0]                     cnt_q, cnt_d;

   logic [12:0]                     bnd_bytes;
   logic [TOTAL_WIDTH-1:0]          bnd_words;
   logic [TOTAL_WIDTH-1:0]          chunk;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   step;

   // Words left before the next 4 KB boundary; always >= 1 for an aligned address.
   always_comb begin
      bnd_bytes = 13'd4096 - {1'b0, cur_addr_q[11:0]};
      bnd_words = TOTAL_WIDTH'(bnd_bytes >> AddrLsb);
      chunk     = rem_q;
      if (MaxChunkW < chunk) chunk = MaxChunkW;
      if (bnd_words < chunk) chunk = bnd_words;
      step      = C_M_AXI_ADDR_WIDTH'(rx_size_q) * C_M_AXI_ADDR_WIDTH'(Bpw);
   end

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      rx_addr_d  = rx_addr_q;
      rx_size_d  = rx_size_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               cur_addr_d = cmd_addr & ~AddrLowMask;
               rem_d      = cmd_words;
               cnt_d      = '0;
               state_d    = StCalc;
            end
         end
         StCalc: begin
            if (rem_q == '0) begin
               state_d = StDone;
            end else begin
               rx_addr_d = cur_addr_q;
               rx_size_d = TX_SIZE_WIDTH'(chunk);
               state_d   = StReq;
            end
         end
         StReq: begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            state_d = StWait;
         end
         StWait: begin
            if (rx_done) begin
               cur_addr_d = cur_addr_q + step;
               rem_d      = rem_q - TOTAL_WIDTH'(rx_size_q);
               state_d    = StCalc;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= StIdle;
         cur_addr_q <= '0;
         rem_q      <= '0;
         rx_addr_q  <= '0;
         rx_size_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         rx_addr_q  <= rx_addr_d;
         rx_size_q  <= rx_size_d;
         cnt_q      <= cnt_d;
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign rx_req      = (state_q == StReq);
   assign cmd_done    = (state_q == StDone);
   assign rx_addr     = rx_addr_q;
   assign rx_req_size = rx_size_q;
   assign chunk_cnt   = cnt_q;

endmodule

// File: tb/tb_axi_rd_req_gen.sv
// Directed bench for axi_rd_req_gen: table of commands with expected chunk lists,
// plus hand-written sequences for back-pressure, mid-command reset and MAX_CHUNK=63.
module tb_axi_rd_req_gen;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, rx_done;
   logic [31:0] cmd_addr;
   logic [19:0] cmd_words;
   logic        cmd_ready, rx_req, busy, cmd_done;
   logic [31:0] rx_addr;
   logic [5:0]  rx_req_size;
   logic [15:0] chunk_cnt;

   logic        m_valid, m_done;
   logic [31:0] m_addr;
   logic [19:0] m_words;
   logic        m_ready, m_req, m_busy, m_cmd_done;
   logic [31:0] m_rx_addr;
   logic [5:0]  m_size;
   logic [15:0] m_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 ACLK = ~ACLK;

   axi_rd_req_gen #(.MAX_CHUNK(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_words(cmd_words), .rx_req(rx_req), .rx_addr(rx_addr),
      .rx_req_size(rx_req_size), .rx_done(rx_done), .busy(busy), .cmd_done(cmd_done),
      .chunk_cnt(chunk_cnt)
   );

   axi_rd_req_gen #(.MAX_CHUNK(63)) dut63 (
      .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(m_valid), .cmd_ready(m_ready),
      .cmd_addr(m_addr), .cmd_words(m_words), .rx_req(m_req), .rx_addr(m_rx_addr),
      .rx_req_size(m_size), .rx_done(m_done), .busy(m_busy), .cmd_done(m_cmd_done),
      .chunk_cnt(m_cnt)
   );

   // ea/es are packed [2:0]: in a concatenation the chunk-2 value comes first.
   typedef struct packed {
      logic [31:0]      addr;
      logic [19:0]      words;
      logic [1:0]       n;
      logic [2:0][31:0] ea;
      logic [2:0][5:0]  es;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input vec_t v);
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_addr = v.addr; cmd_words = v.words;
      chk("accept_ready", 32'(cmd_ready), 32'd1);
      @(negedge ACLK);                      // CALC
      cmd_valid = 1'b0;
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_no_req", 32'(rx_req), 32'd0);
      for (int i = 0; i < int'(v.n); i++) begin
         @(negedge ACLK);                   // REQ
         chk("req_pulse", 32'(rx_req), 32'd1);
         chk("req_addr", rx_addr, v.ea[i]);
         chk("req_size", 32'(rx_req_size), 32'(v.es[i]));
         @(negedge ACLK);                   // WAIT
         chk("wait_no_req", 32'(rx_req), 32'd0);
         chk("wait_cnt", 32'(chunk_cnt), 32'(i + 1));
         @(negedge ACLK);
         chk("wait_addr_hold", rx_addr, v.ea[i]);
         @(negedge ACLK);
         rx_done = 1'b1;
         @(negedge ACLK);                   // CALC
         rx_done = 1'b0;
         chk("post_done_no_req", 32'(rx_req), 32'd0);
      end
      @(negedge ACLK);                      // DONE
      chk("cmd_done", 32'(cmd_done), 32'd1);
      chk("done_no_req", 32'(rx_req), 32'd0);
      chk("done_cnt", 32'(chunk_cnt), 32'(v.n));
      @(negedge ACLK);                      // IDLE
      chk("idle_done_low", 32'(cmd_done), 32'd0);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{32'h1000, 20'd40, 2'd3, {32'h1100, 32'h1080, 32'h1000}, {6'd8, 6'd16, 6'd16}};
      vecs[1] = '{32'h0FF0, 20'd10, 2'd2, {32'h0, 32'h1000, 32'h0FF0}, {6'd0, 6'd8, 6'd2}};
      vecs[2] = '{32'h0, 20'd0, 2'd0, {32'h0, 32'h0, 32'h0}, {6'd0, 6'd0, 6'd0}};
      vecs[3] = '{32'h1003, 20'd1, 2'd1, {32'h0, 32'h0, 32'h1000}, {6'd0, 6'd0, 6'd1}};
      vecs[4] = '{32'hFFFF_FFF8, 20'd3, 2'd2, {32'h0, 32'h0, 32'hFFFF_FFF8}, {6'd0, 6'd2, 6'd1}};

      ARESET = 1'b1; cmd_valid = 1'b0; rx_done = 1'b0; cmd_addr = '0; cmd_words = '0;
      m_valid = 1'b0; m_done = 1'b0; m_addr = '0; m_words = '0;
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req", 32'(rx_req), 32'd0);
      chk("rst_addr", rx_addr, 32'd0);
      chk("rst_size", 32'(rx_req_size), 32'd0);
      chk("rst_cnt", 32'(chunk_cnt), 32'd0);

      for (int k = 0; k < 5; k++) run_cmd(vecs[k]);

      // rx_done in IDLE, rx_done in CALC, cmd_valid held while busy.
      rx_done = 1'b1;
      @(negedge ACLK);
      rx_done = 1'b0;
      chk("idle_rxdone_busy", 32'(busy), 32'd0);
      cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_words = 20'd16;
      @(negedge ACLK);                      // CALC
      cmd_addr = 32'h5000; cmd_words = 20'd1; rx_done = 1'b1;
      chk("bp_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge ACLK);                      // REQ
      rx_done = 1'b0;
      chk("bp_req", 32'(rx_req), 32'd1);
      chk("bp_addr", rx_addr, 32'h3000);
      chk("bp_size", 32'(rx_req_size), 32'd16);
      @(negedge ACLK);                      // WAIT
      chk("bp_wait_ready", 32'(cmd_ready), 32'd0);
      chk("bp_wait_cnt", 32'(chunk_cnt), 32'd1);
      rx_done = 1'b1;
      @(negedge ACLK);                      // CALC
      rx_done = 1'b0;
      @(negedge ACLK);                      // DONE
      chk("bp_cmd_done", 32'(cmd_done), 32'd1);
      chk("bp_done_ready", 32'(cmd_ready), 32'd0);
      @(negedge ACLK);                      // IDLE, held command taken at next edge
      chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
      @(negedge ACLK);                      // CALC of second command
      cmd_valid = 1'b0;
      chk("bp2_busy", 32'(busy), 32'd1);
      chk("bp2_cnt_clr", 32'(chunk_cnt), 32'd0);
      @(negedge ACLK);                      // REQ
      chk("bp2_req", 32'(rx_req), 32'd1);
      chk("bp2_addr", rx_addr, 32'h5000);
      chk("bp2_size", 32'(rx_req_size), 32'd1);
      @(negedge ACLK);
      rx_done = 1'b1;
      @(negedge ACLK);
      rx_done = 1'b0;
      @(negedge ACLK);
      chk("bp2_cmd_done", 32'(cmd_done), 32'd1);
      @(negedge ACLK);

      // Reset during WAIT of chunk 2.
      cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_words = 20'd40;
      @(negedge ACLK);
      cmd_valid = 1'b0;
      @(negedge ACLK);                      // REQ 1
      @(negedge ACLK);                      // WAIT 1
      rx_done = 1'b1;
      @(negedge ACLK);
      rx_done = 1'b0;
      @(negedge ACLK);                      // REQ 2
      chk("mr_req2_addr", rx_addr, 32'h1080);
      @(negedge ACLK);                      // WAIT 2
      chk("mr_wait_cnt", 32'(chunk_cnt), 32'd2);
      #2 ARESET = 1'b1;
      #1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_req", 32'(rx_req), 32'd0);
      chk("mr_addr", rx_addr, 32'd0);
      chk("mr_size", 32'(rx_req_size), 32'd0);
      chk("mr_cnt", 32'(chunk_cnt), 32'd0);
      chk("mr_cmd_done", 32'(cmd_done), 32'd0);
      @(negedge ACLK);
      ARESET = 1'b0;
      rx_done = 1'b1;
      @(negedge ACLK);
      rx_done = 1'b0;
      chk("mr_stray_busy", 32'(busy), 32'd0);
      chk("mr_stray_req", 32'(rx_req), 32'd0);
      run_cmd('{32'h2000, 20'd5, 2'd1, {32'h0, 32'h0, 32'h2000}, {6'd0, 6'd0, 6'd5}});

      // MAX_CHUNK = 63 instance: (0x000,63) then (0x1F8,63).
      m_valid = 1'b1; m_addr = 32'h0; m_words = 20'd126;
      @(negedge ACLK);
      m_valid = 1'b0;
      @(negedge ACLK);
      chk("m63_req1", 32'(m_req), 32'd1);
      chk("m63_addr1", m_rx_addr, 32'h0);
      chk("m63_size1", 32'(m_size), 32'd63);
      @(negedge ACLK);
      m_done = 1'b1;
      @(negedge ACLK);
      m_done = 1'b0;
      @(negedge ACLK);
      chk("m63_req2", 32'(m_req), 32'd1);
      chk("m63_addr2", m_rx_addr, 32'h1F8);
      chk("m63_size2", 32'(m_size), 32'd63);
      @(negedge ACLK);
      m_done = 1'b1;
      @(negedge ACLK);
      m_done = 1'b0;
      @(negedge ACLK);
      chk("m63_cmd_done", 32'(m_cmd_done), 32'd1);
      chk("m63_cnt", 32'(m_cnt), 32'd2);
      @(negedge ACLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_rd_req_gen.md
Name: axi_rd_req_gen

Overview:
- Upstream request generator for the AXI master's read path.
- Accepts one bulk read command (byte base address + total 64-bit word count) and splits it into a sequence of rx_req transactions.
- Each chunk is bounded by MAX_CHUNK words and never crosses a 4 KB address boundary; the next chunk is issued only after rx_done for the current one.
- Signals command completion to the NPU controller.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, byte address width.
- C_M_AXI_DATA_WIDTH, 64, data word width; bytes per word BPW = C_M_AXI_DATA_WIDTH/8 (8).
- TX_SIZE_WIDTH, 6, width of rx_req_size.
- TOTAL_WIDTH, 20, width of the command word count.
- MAX_CHUNK, 16, maximum words per rx_req; legal range 1..2^TX_SIZE_WIDTH-1.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte base address; low log2(BPW) bits ignored (treated as 0).
- cmd_words  in  TOTAL_WIDTH  total words to read.
- rx_req  out  1  one-cycle request pulse to the AXI master.
- rx_addr  out  C_M_AXI_ADDR_WIDTH  chunk byte address; stable from the rx_req cycle until rx_done.
- rx_req_size  out  TX_SIZE_WIDTH  chunk word count; stable alongside rx_addr.
- rx_done  in  1  one-cycle pulse from the AXI master: chunk complete.
- busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle pulse when the command finishes.
- chunk_cnt  out  16  chunks issued for the current command; cleared on accept, saturates at 0xFFFF.

Behaviour:
- Reset (async, ARESET=1): state=IDLE; rx_req=0, rx_addr=0, rx_req_size=0, busy=0, cmd_done=0, chunk_cnt=0; internal addr/remaining=0; cmd_ready=1 after release.
- A reset asserted mid-command abandons the command immediately; any rx_done arriving afterwards while IDLE is ignored.
- FSM states: IDLE, CALC, REQ, WAIT, DONE.
- IDLE:
  - cmd_valid & cmd_ready at edge T latches cur_addr = cmd_addr with low bits cleared, and rem = cmd_words.
  - Clears chunk_cnt; goes to CALC.
  - cmd_valid in any other state is ignored (cmd_ready=0).
- CALC (one cycle):
  - If rem==0, go to DONE (zero-word command: no rx_req is ever issued).
  - Otherwise compute bnd = (4096 - cur_addr[11:0]) / BPW and chunk = min(rem, MAX_CHUNK, bnd).
  - Register rx_addr=cur_addr and rx_req_size=chunk; go to REQ.
- REQ (one cycle): rx_req=1; chunk_cnt increments (saturating); go to WAIT.
- WAIT:
  - Hold rx_addr and rx_req_size.
  - On rx_done: cur_addr += chunk*BPW (wraps modulo 2^C_M_AXI_ADDR_WIDTH); rem -= chunk; go to CALC.
  - rx_done seen in any other state is ignored.
  - No timeout.
- DONE (one cycle): cmd_done=1; go to IDLE.
- Latency:
  - Accept at T gives rx_req at T+2.
  - rx_done at D gives the next rx_req at D+2, or cmd_done at D+2 for the last chunk (via CALC→DONE).
- Arithmetic:
  - chunk ≥ 1 always, because rem>0 and bnd≥1.
  - rem never underflows.
  - The min() compare is done at TOTAL_WIDTH bits, then truncated to TX_SIZE_WIDTH (safe since chunk ≤ MAX_CHUNK).
- Address wrap at 2^ADDR: allowed, no error.

Test Plan:
- Chunking: cmd_addr=0x1000, cmd_words=40, rx_done 3 cycles after each rx_req → rx_req ×3 with (addr,size) = (0x1000,16), (0x1080,16), (0x1100,8); cmd_done 2 cycles after the third rx_done; chunk_cnt=3.
- 4 KB crossing: cmd_addr=0x0FF0, cmd_words=10 → (0x0FF0,2) then (0x1000,8); no chunk spans 0x1000.
- Zero / misaligned:
  - cmd_words=0 → cmd_done pulse at T+2, no rx_req, chunk_cnt=0.
  - cmd_addr=0x1003, cmd_words=1 → single (0x1000,1).
- Back-pressure:
  - cmd_valid held high while busy → cmd_ready=0 and the second command is not taken.
  - rx_done pulsed in IDLE or CALC → no state change.
  - Second command is accepted the cycle after cmd_done.
- Reset mid-operation: assert ARESET during WAIT of chunk 2 → all outputs go to reset values asynchronously; a stray rx_done after release is ignored; a new cmd (0x2000, 5) yields a single (0x2000,5).
- Max chunk edge: MAX_CHUNK=63, cmd_addr=0, cmd_words=126 → (0x000,63), (0x1F8,63); rx_req_size=63 with no truncation.
